// File: rtl/run_sequencer.sv
// Run controller for the core's start/halt handshake. It launches either one program or
// all programs in order and reports cycles per run. Latency: go->start is 1 cycle and halt->done is 2 cycles; go is ignored while busy.
module run_sequencer #(
  parameter int NUM_PROGS    = 3,
  parameter int PROG_W       = 2,
  parameter int START_CYCLES = 2,
  parameter int CNT_W        = 16,
  parameter int TIMEOUT      = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 go,
  input  logic                 run_all,
  input  logic [PROG_W-1:0]    prog_sel,
  input  logic                 halt,
  output logic                 start,
  output logic [PROG_W-1:0]    prog_id,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [NUM_PROGS-1:0] runs_ok
);

  localparam int                LW          = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [LW-1:0]     LAUNCH_LAST = LW'(START_CYCLES - 1);
  localparam logic [PROG_W-1:0] LAST_PROG   = PROG_W'(NUM_PROGS - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_C   = CNT_W'(TIMEOUT);
  localparam logic [PROG_W:0]   NUM_PROGS_C = (PROG_W + 1)'(NUM_PROGS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_NEXT,
    S_DONE
  } state_t;

  state_t           state;
  logic             all_q;
  logic [LW-1:0]    lcnt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             sel_ok;

  assign cnt_inc = cnt + CNT_W'(1);
  // An out-of-range single-program request is dropped rather than launching a nonexistent program.
  assign sel_ok  = run_all || ({1'b0, prog_sel} < NUM_PROGS_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      all_q       <= 1'b0;
      lcnt        <= '0;
      cnt         <= '0;
      start       <= 1'b0;
      prog_id     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      cycle_count <= '0;
      runs_ok     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go && sel_ok) begin
            state       <= S_LAUNCH;
            all_q       <= run_all;
            prog_id     <= run_all ? '0 : prog_sel;
            runs_ok     <= '0;
            timeout_err <= 1'b0;
            cnt         <= '0;
            lcnt        <= '0;
            start       <= 1'b1;
            busy        <= 1'b1;
          end
        end

        // halt is deliberately not looked at here: the core is still being started.
        S_LAUNCH: begin
          if (lcnt == LAUNCH_LAST) begin
            start <= 1'b0;
            state <= S_RUN;
          end else begin
            lcnt <= lcnt + LW'(1);
          end
        end

        // cnt holds completed RUN cycles, so cnt_inc is the number of the current cycle.
        // The state is left at TIMEOUT, so the counter can never wrap.
        S_RUN: begin
          if (halt) begin
            cycle_count      <= cnt_inc;
            runs_ok[prog_id] <= 1'b1;
            state            <= S_NEXT;
          end else if (cnt_inc == TIMEOUT_C) begin
            cycle_count <= TIMEOUT_C;
            timeout_err <= 1'b1;
            state       <= S_NEXT;
          end else begin
            cnt <= cnt_inc;
          end
        end

        S_NEXT: begin
          if (all_q && (prog_id < LAST_PROG)) begin
            prog_id <= prog_id + PROG_W'(1);
            cnt     <= '0;
            lcnt    <= '0;
            start   <= 1'b1;
            state   <= S_LAUNCH;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Randomised bench for run_sequencer: the bench acts as the core and checks against a per-program latency model.
module tb_run_sequencer;

  localparam int NP  = 3;
  localparam int TMO = 20;
  localparam int SC  = 2;

  logic        clk;
  logic        rst_n;
  logic        go;
  logic        run_all;
  logic [1:0]  prog_sel;
  logic        halt;
  logic        start;
  logic [1:0]  prog_id;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic [15:0] cycle_count;
  logic [2:0]  runs_ok;

  int tests;
  int fails;

  // Values the model expects the DUT to hold while idle.
  logic [15:0] g_cc;
  logic [2:0]  g_ok;
  logic        g_te;
  logic [1:0]  g_pid;

  run_sequencer #(
    .NUM_PROGS(NP), .PROG_W(2), .START_CYCLES(SC), .CNT_W(16), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .run_all(run_all), .prog_sel(prog_sel),
    .halt(halt), .start(start), .prog_id(prog_id), .busy(busy), .done(done),
    .timeout_err(timeout_err), .cycle_count(cycle_count), .runs_ok(runs_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lat[p] = RUN cycle on which program p halts; 0 (or > TMO) means it never halts.
  // mode bit0: halt pulse in first LAUNCH cycle; bit1: go pulse in RUN; bit2: halt held high throughout.
  task automatic run_seq(input bit all, input logic [1:0] sel, input int l0, input int l1,
                         input int l2, input int mode, input string name);
    int lat[3];
    int progs[$];
    int launched[$];
    int slen[$];
    int exp_done_idx, ecc, r, p;
    logic [2:0] eok;
    bit ete;
    int cur_slen, run_len, done_idx, done_cnt, busy_bad;
    bit in_run, prev_start;

    lat[0] = l0; lat[1] = l1; lat[2] = l2;
    if (all) begin
      for (int i = 0; i < NP; i++) progs.push_back(i);
    end else begin
      progs.push_back(int'(sel));
    end
    exp_done_idx = 0; eok = '0; ete = 1'b0; ecc = 0;
    foreach (progs[i]) begin
      p = progs[i];
      if (lat[p] >= 1 && lat[p] <= TMO) begin
        r = lat[p];
        eok[p] = 1'b1;
      end else begin
        r = TMO;
        ete = 1'b1;
      end
      ecc = r;
      exp_done_idx += SC + r + 1;
    end

    @(posedge clk); #1;
    go = 1'b1; run_all = all; prog_sel = sel;
    if (mode[2]) halt = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;

    prev_start = 1'b0; in_run = 1'b0; run_len = 0; cur_slen = 0;
    done_idx = -1; done_cnt = 0; busy_bad = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (start) begin
        if (!prev_start) begin
          launched.push_back(int'(prog_id));
          cur_slen = 0; in_run = 1'b1; run_len = 0;
          if (mode[0] && launched.size() == 1) halt = 1'b1;
        end
        cur_slen++;
      end else begin
        if (prev_start) slen.push_back(cur_slen);
        if (in_run) begin
          run_len++;
          if (launched.size() > 0 && run_len == lat[launched[$]]) begin
            halt = 1'b1;
            in_run = 1'b0;
          end
          if (mode[1] && run_len == 2) go = 1'b1;
        end
      end
      if (done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = c;
      end
      if (busy !== (c < exp_done_idx)) busy_bad++;
      prev_start = start;
      @(posedge clk); #1;
      if (!mode[2]) halt = 1'b0;
      go = 1'b0;
      if (done_idx >= 0 && c >= done_idx + 2) break;
    end
    halt = 1'b0;

    tests++;
    if (launched.size() !== progs.size()) begin
      fails++;
      $display("FAIL %s launch_count: got %0d expected %0d", name, launched.size(), progs.size());
    end else begin
      foreach (progs[i]) begin
        tests++;
        if (launched[i] !== progs[i]) begin
          fails++;
          $display("FAIL %s launch_prog[%0d]: got %0d expected %0d", name, i, launched[i], progs[i]);
        end
      end
    end
    foreach (slen[i]) begin
      tests++;
      if (slen[i] !== SC) begin
        fails++;
        $display("FAIL %s start_len[%0d]: got %0d expected %0d", name, i, slen[i], SC);
      end
    end
    tests++;
    if (done_idx !== exp_done_idx) begin
      fails++;
      $display("FAIL %s done_time: got %0d expected %0d", name, done_idx, exp_done_idx);
    end
    tests++;
    if (done_cnt !== 1) begin
      fails++;
      $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
    end
    tests++;
    if (busy_bad !== 0) begin
      fails++;
      $display("FAIL %s busy: %0d wrong cycles, expected 0", name, busy_bad);
    end
    tests++;
    if (cycle_count !== 16'(ecc)) begin
      fails++;
      $display("FAIL %s cycle_count: got %0d expected %0d", name, cycle_count, ecc);
    end
    tests++;
    if (runs_ok !== eok) begin
      fails++;
      $display("FAIL %s runs_ok: got %b expected %b", name, runs_ok, eok);
    end
    tests++;
    if (timeout_err !== ete) begin
      fails++;
      $display("FAIL %s timeout_err: got %b expected %b", name, timeout_err, ete);
    end
    tests++;
    if (prog_id !== 2'(progs[$])) begin
      fails++;
      $display("FAIL %s prog_id_hold: got %0d expected %0d", name, prog_id, progs[$]);
    end
    g_cc = 16'(ecc); g_ok = eok; g_te = ete; g_pid = 2'(progs[$]);
  endtask

  task automatic check_reset_vals(input string name);
    tests++;
    if ({start, busy, done, timeout_err, prog_id, runs_ok, cycle_count} !== 24'h0) begin
      fails++;
      $display("FAIL %s: start=%b busy=%b done=%b te=%b pid=%0d ok=%b cc=%0d expected all zero",
               name, start, busy, done, timeout_err, prog_id, runs_ok, cycle_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; go = 1'b0; run_all = 1'b0; prog_sel = '0; halt = 1'b0;
    #12;
    check_reset_vals("reset_state");
    @(negedge clk); rst_n = 1'b1;
    g_cc = '0; g_ok = '0; g_te = 1'b0; g_pid = '0;
  endtask

  task automatic test_single();
    run_seq(1'b0, 2'd1, 0, 10, 0, 0, "single");
  endtask

  task automatic test_run_all();
    run_seq(1'b1, 2'd0, 5, 7, 9, 0, "run_all");
  endtask

  task automatic test_timeout();
    run_seq(1'b0, 2'd2, 0, 0, 0, 0, "timeout");
    run_seq(1'b0, 2'd0, 3, 0, 0, 0, "timeout_clear");
    run_seq(1'b0, 2'd0, TMO, 0, 0, 0, "halt_at_timeout");
  endtask

  task automatic test_hang_mid();
    run_seq(1'b1, 2'd0, 4, 0, 6, 0, "hang_mid");
  endtask

  task automatic test_ignored_go();
    @(posedge clk); #1;
    go = 1'b1; run_all = 1'b0; prog_sel = 2'd3;
    @(posedge clk); #1;
    go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if ({busy, start, done, timeout_err, runs_ok, cycle_count, prog_id} !==
          {3'b000, g_te, g_ok, g_cc, g_pid}) begin
        fails++;
        $display("FAIL bad_sel cycle %0d: busy=%b start=%b done=%b te=%b ok=%b cc=%0d pid=%0d expected idle te=%b ok=%b cc=%0d pid=%0d",
                 i, busy, start, done, timeout_err, runs_ok, cycle_count, prog_id, g_te, g_ok, g_cc, g_pid);
      end
    end
    run_seq(1'b0, 2'd1, 0, 8, 0, 3, "launch_halt_and_go_in_run");
  endtask

  task automatic test_halt_held();
    run_seq(1'b1, 2'd0, 1, 1, 1, 4, "halt_held");
  endtask

  task automatic test_reset_midrun();
    int waited;
    @(posedge clk); #1;
    go = 1'b1; run_all = 1'b1; prog_sel = 2'd0;
    @(posedge clk); #1;
    go = 1'b0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(prog_id == 2'd1 && busy && !start) && waited < 200);
    tests++;
    if (waited >= 200) begin
      fails++;
      $display("FAIL midrun_reach: prog 1 never entered RUN within %0d cycles", waited);
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrun_reset");
    @(negedge clk); rst_n = 1'b1;
    g_cc = '0; g_ok = '0; g_te = 1'b0; g_pid = '0;
    run_seq(1'b0, 2'd2, 0, 0, 4, 0, "after_reset");
  endtask

  task automatic test_random();
    int l[3];
    int kind;
    bit all;
    logic [1:0] sel;
    for (int it = 0; it < 10; it++) begin
      for (int p = 0; p < 3; p++) begin
        kind = int'($urandom_range(0, 3));
        if (kind == 0) l[p] = 0;
        else if (kind == 1) l[p] = TMO;
        else l[p] = int'($urandom_range(1, TMO));
      end
      all = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(0, 2));
      run_seq(all, sel, l[0], l[1], l[2], 0, "random");
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    test_reset();
    test_single();
    test_run_all();
    test_timeout();
    test_hang_mid();
    test_ignored_go();
    test_halt_held();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
Synthesizable run controller that sits between the board/bench and top_level. It drives the core's start/halt handshake for one or several programs back-to-back. It measures cycles per run and flags runs that never halt. It generalises the single fixed start-pulse/halt-wait sequence into a parametrised multi-program, timeout-guarded sequencer.

Parameters:
NUM_PROGS, 3, number of programs selectable via prog_id (≥1)
PROG_W, 2, width of prog_id/prog_sel; must satisfy 2**PROG_W ≥ NUM_PROGS
START_CYCLES, 2, cycles start is held high per launch (≥1)
CNT_W, 16, width of cycle counter
TIMEOUT, 1000, RUN-state cycles before a run is declared hung (< 2**CNT_W)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
go  in  1  request; sampled only in IDLE
run_all  in  1  sampled with go: 1 = run programs 0..NUM_PROGS-1 in order, 0 = run prog_sel only
prog_sel  in  PROG_W  program to run when run_all=0
halt  in  1  from top_level
start  out  1  to top_level
prog_id  out  PROG_W  program currently launched/running
busy  out  1  high in any state except IDLE/DONE
done  out  1  one-cycle pulse when the sequence finishes
timeout_err  out  1  sticky; set on any hung run, cleared by next accepted go
cycle_count  out  CNT_W  cycles of last completed/aborted run
runs_ok  out  NUM_PROGS  bit i set when program i halted normally in current sequence

Behaviour:
Reset (async, rst_n=0): state IDLE; start=0, prog_id=0, busy=0, done=0, timeout_err=0, cycle_count=0, runs_ok=0. Reset mid-run aborts immediately; start drops the same instant.
States:
- IDLE: go=1 -> LAUNCH next cycle. Latch run_all. prog_id <= run_all ? 0 : prog_sel. Clear runs_ok and timeout_err; clear internal counter. prog_sel ≥ NUM_PROGS with run_all=0: go ignored, stay IDLE.
- LAUNCH: start=1 for exactly START_CYCLES consecutive cycles, then RUN. halt ignored during LAUNCH (core is held in reset/start).
- RUN: start=0. Counter increments every cycle, starting from 1 on the first RUN cycle.
  - halt=1: cycle_count <= counter, runs_ok[prog_id] <= 1, -> NEXT.
  - Counter reaches TIMEOUT with halt=0: cycle_count <= TIMEOUT, timeout_err <= 1, runs_ok bit stays 0, -> NEXT.
  - Halt on the same cycle the counter reaches TIMEOUT counts as a normal halt.
- NEXT (1 cycle, start=0):
  - run_all=1 and prog_id < NUM_PROGS-1: prog_id++, counter cleared, -> LAUNCH.
  - Otherwise -> DONE.
  - A timeout does not stop a run_all sequence.
- DONE (1 cycle): done=1 -> IDLE. prog_id, cycle_count, runs_ok and timeout_err hold their values until the next accepted go.
Total latency, single program: go to first start = 1 cycle; halt to done = 2 cycles (NEXT, DONE).
go while busy: ignored, no queuing.
halt held high across launches: after LAUNCH it is seen on the first RUN cycle, giving cycle_count=1.
Counter saturates; it never wraps, since TIMEOUT < 2**CNT_W.

Test Plan:
- Reset, go=1, run_all=0, prog_sel=1; halt raised on the 10th RUN cycle -> start high exactly 2 cycles, prog_id=1, cycle_count=10, runs_ok=3'b010, done pulses once 2 cycles after halt, timeout_err=0.
- run_all=1, halts after 5/7/9 RUN cycles -> three 2-cycle start pulses with prog_id 0,1,2, each separated by NEXT; final cycle_count=9, runs_ok=3'b111, single done.
- TIMEOUT=20, halt never asserted, run_all=0 -> after 20 RUN cycles cycle_count=20, timeout_err=1, runs_ok=0, done pulses; a second go clears timeout_err.
- run_all=1, program 1 hangs -> program 2 still launched, runs_ok=3'b101, timeout_err=1 after done.
- rst_n pulsed low mid-RUN of program 1 -> all outputs return to reset values immediately (start=0, busy=0); go after release starts cleanly from IDLE.
- go during RUN, and go with prog_sel=3 (NUM_PROGS=3) in IDLE -> no effect on state or outputs; halt pulse during LAUNCH -> ignored, run continues to RUN.
